item_assembler: RTL and testbench

- Upstream stage of the per-unit item distributor.
- Consumes a framed byte stream from the host input FIFO, assembles WIDTH-bit items, and presents them with a broadcast flag.
- Output uses the distributor's write-side handshake: data, bcast, write-enable and full.
- Single output buffer; the input stalls while an item waits for the downstream.

---
 rtl/item_assembler_pkg.sv | 24 ++
 rtl/item_assembler.sv | 162 ++++++++++++++++
 tb/tb_item_assembler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/item_assembler_pkg.sv
// Shared types and constants for the item assembler.
// Holds the state encoding, the error codes and the byte-count helper.
package item_assembler_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_PAYLOAD,
        S_CSUM,
        S_OUT,
        S_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_TYPE = 2'b01;
    localparam logic [1:0] ERR_CSUM     = 2'b10;

    // A header whose type field is zero is line padding.
    localparam logic [6:0] PAD_TYPE = 7'd0;

    function automatic int n_bytes_f(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/item_assembler.sv
// Assembles WIDTH-bit items from a framed byte stream (header, payload
// bytes little-endian, optional checksum byte) and hands each item to the
// distributor write port. Single output buffer: the input stalls (full=1)
// while an assembled item waits.
// Ports: CLK, RST_N (async, active low); din/wr_en/full byte input side;
// dout/bcast/dout_wr_en/dout_full distributor side; err/err_code sticky
// framing error; item_count items delivered since reset (wraps).
// Build option: define ITEM_ASSEMBLER_CHECKSUM_EN to expect and verify a
// trailing mod-256 checksum byte per frame.
module item_assembler
    import item_assembler_pkg::*;
#(
    parameter int WIDTH     = 56,
    parameter int ITEM_TYPE = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [7:0]       din,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    output logic             bcast,
    output logic             dout_wr_en,
    input  logic             dout_full,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [15:0]      item_count
);

    localparam int N_BYTES = n_bytes_f(WIDTH);
    localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int WB      = 8 * N_BYTES;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_BYTES - 1);
    localparam logic [6:0]       TYPE_VAL  = 7'(ITEM_TYPE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               bcast_q, bcast_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [15:0]        item_count_q, item_count_d;
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic               accept;
    logic [CNT_W+2:0]   shamt;
    logic [WB-1:0]      ins;
    logic [WB-1:0]      msk;

    assign full       = (state_q == S_OUT) || (state_q == S_ERR);
    assign dout_wr_en = (state_q == S_OUT) && !dout_full;
    assign err        = (state_q == S_ERR);
    assign err_code   = err_code_q;
    assign dout       = dout_q;
    assign bcast      = bcast_q;
    assign item_count = item_count_q;

    assign accept = wr_en && !full;

    // Byte lane k sits at bit 8k; lanes above WIDTH fall off the slice.
    assign shamt = {cnt_q, 3'b000};
    assign ins   = WB'(din) << shamt;
    assign msk   = WB'(8'hFF) << shamt;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        bcast_d      = bcast_q;
        err_code_d   = err_code_q;
        item_count_d = item_count_q;
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        unique case (state_q)
            S_HDR: begin
                if (accept && din[6:0] != PAD_TYPE) begin
                    if (din[6:0] == TYPE_VAL) begin
                        bcast_d = din[7];
                        cnt_d   = '0;
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
                        sum_d   = din;
`endif
                        state_d = S_PAYLOAD;
                    end else begin
                        err_code_d = ERR_BAD_TYPE;
                        state_d    = S_ERR;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    dout_d = (dout_q & ~msk[WIDTH-1:0])
                           | ins[WIDTH-1:0];
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
                    sum_d  = sum_q + din;
`endif
                    if (cnt_q == LAST_IDX) begin
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_OUT;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (din == sum_q) begin
                        state_d = S_OUT;
                    end else begin
                        err_code_d = ERR_CSUM;
                        state_d    = S_ERR;
                    end
                end
            end
`endif
            S_OUT: begin
                if (dout_wr_en) begin
                    item_count_d = item_count_q + 16'd1;
                    state_d      = S_HDR;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_HDR;
            cnt_q        <= '0;
            dout_q       <= '0;
            bcast_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
            item_count_q <= '0;
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            bcast_q      <= bcast_d;
            err_code_q   <= err_code_d;
            item_count_q <= item_count_d;
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_item_assembler.sv
// Directed testbench for item_assembler with an expected-item queue.
// Build with ITEM_ASSEMBLER_CHECKSUM_EN to also cover the checksum path.
module tb_item_assembler;

    localparam int WIDTH = 56;
    localparam int N     = 7;

    logic             CLK;
    logic             RST_N;
    logic [7:0]       din;
    logic             wr_en;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic             bcast;
    logic             dout_wr_en;
    logic             dout_full;
    logic             err;
    logic [1:0]       err_code;
    logic [15:0]      item_count;

    item_assembler #(.WIDTH(WIDTH), .ITEM_TYPE(1)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .din        (din),
        .wr_en      (wr_en),
        .full       (full),
        .dout       (dout),
        .bcast      (bcast),
        .dout_wr_en (dout_wr_en),
        .dout_full  (dout_full),
        .err        (err),
        .err_code   (err_code),
        .item_count (item_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    logic [WIDTH:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write pulse pops one expected item.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && dout_wr_en === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_item", 64'(dout), 64'hDEAD);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("item_dout", 64'(dout), 64'(e[WIDTH-1:0]));
                check("item_bcast", 64'(bcast), 64'(e[WIDTH]));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (full !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $error("FAIL send_timeout: observed full=%0b expected 0", full);
        end
        din   = b;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] build(input logic [7:0] p [N]);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[8*k +: 8] = p[k];
        return v;
    endfunction

    task automatic send_frame(input logic [7:0] hdr,
                              input logic [7:0] p [N],
                              input bit push,
                              input logic [7:0] csum_xor);
        logic [7:0] sum;
        if (push) exp_q.push_back({hdr[7], build(p)});
        sum = hdr;
        send(hdr);
        for (int k = 0; k < N; k++) begin
            sum = sum + p[k];
            send(p[k]);
        end
`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
        send(sum ^ csum_xor);
`else
        if (csum_xor != 8'h00) sum = 8'h00;
`endif
    endtask

    task automatic wait_items(input logic [15:0] target);
        int n;
        n = 0;
        while (item_count !== target && n < 50) begin
            step();
            n++;
        end
        check("item_count", 64'(item_count), 64'(target));
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        #2;
        check("rst_full", 64'(full), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_item_count", 64'(item_count), 64'd0);
        check("rst_wr_en", 64'(dout_wr_en), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_bcast", 64'(bcast), 64'd0);
        step();
        RST_N = 1'b1;
        step();
    endtask

    logic [7:0]       pl [N];
    logic [WIDTH-1:0] hold;
    int               bad;

    initial begin
        RST_N     = 1'b0;
        din       = 8'h00;
        wr_en     = 1'b0;
        dout_full = 1'b0;
        step();
        apply_reset();

        // Decode: padding, header, payload 07..01 little-endian.
        exp_q.push_back({1'b0, 56'h01020304050607});
        send(8'h00);
        pl = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        send_frame(8'h01, pl, 1'b0, 8'h00);
        wait_items(16'd1);
        check("pulses_a", 64'(pulses), 64'd1);

        // Broadcast header preceded by a bcast-flagged padding byte.
        send(8'h80);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_frame(8'h81, pl, 1'b1, 8'h00);
        wait_items(16'd2);
        check("pulses_b", 64'(pulses), 64'd2);

        // Backpressure: item must wait intact, input must stall.
        dout_full = 1'b1;
        pl = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'hF5, 8'h96};
        hold = 56'h96F5E4D3C2B1A0;
        send_frame(8'h01, pl, 1'b1, 8'h00);
        step();
        din   = 8'h05;
        wr_en = 1'b1;
        bad   = 0;
        for (int i = 0; i < 10; i++) begin
            if (full !== 1'b1 || dout_wr_en !== 1'b0 || dout !== hold)
                bad++;
            step();
        end
        check("bp_stall_cycles_bad", 64'(bad), 64'd0);
        check("bp_pulses", 64'(pulses), 64'd2);
        wr_en     = 1'b0;
        dout_full = 1'b0;
        wait_items(16'd3);
        check("bp_release_pulses", 64'(pulses), 64'd3);
        check("bp_no_err", 64'(err), 64'd0);
        pl = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h81};
        send_frame(8'h01, pl, 1'b1, 8'h00);
        wait_items(16'd4);
        check("bp_next_pulses", 64'(pulses), 64'd4);

        // Reset mid-payload discards the partial item.
        send(8'h01);
        send(8'hEE);
        send(8'hEE);
        send(8'hEE);
        apply_reset();
        pulses = 0;
        pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
        send_frame(8'h01, pl, 1'b1, 8'h00);
        wait_items(16'd1);
        for (int i = 0; i < 5; i++) step();
        check("mid_rst_pulses", 64'(pulses), 64'd1);
        check("mid_rst_queue", 64'(exp_q.size()), 64'd0);

`ifdef ITEM_ASSEMBLER_CHECKSUM_EN
        // Checksum 0x1D is correct; 0x1C must be rejected.
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_frame(8'h01, pl, 1'b1, 8'h00);
        wait_items(16'd2);
        send_frame(8'h01, pl, 1'b0, 8'h01);
        for (int i = 0; i < 5; i++) step();
        check("csum_err", 64'(err), 64'd1);
        check("csum_err_code", 64'(err_code), 64'd2);
        check("csum_pulses", 64'(pulses), 64'd2);
        check("csum_full", 64'(full), 64'd1);
        apply_reset();
`endif

        // Bad header type: sticky error until reset.
        send(8'h05);
        check("bad_err", 64'(err), 64'd1);
        check("bad_err_code", 64'(err_code), 64'd1);
        din   = 8'h01;
        wr_en = 1'b1;
        bad   = 0;
        for (int i = 0; i < 100; i++) begin
            if (full !== 1'b1 || err !== 1'b1 || dout_wr_en !== 1'b0)
                bad++;
            step();
        end
        wr_en = 1'b0;
        check("bad_stuck_cycles_bad", 64'(bad), 64'd0);
        check("bad_err_code_hold", 64'(err_code), 64'd1);
        apply_reset();
        check("post_rst_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
